// File: rtl/data_memory_responder.sv
// Multi-cycle word-wide data memory responder for the MEM stage (load/store, one transaction at a time).
// Latency: rsp_valid asserts LATENCY cycles after the accept edge. A new request can be accepted one cycle after RESP.
// Backpressure: mem_stall freezes the pipeline from request until RESP. req_* is sampled only on the accept edge.
//
// Ports:
//   clk, rst                            - rising-edge clock, asynchronous active-high reset
//   req_valid/req_write/req_addr/req_wdata - load/store request; req_addr is a byte address
//   mem_stall, busy                     - hazard-unit freeze request, and transaction-in-flight flag
//   rsp_valid/rsp_rdata/rsp_err         - one-cycle response pulse, with registered data and misalignment flag
module data_memory_responder #(
    parameter int LATENCY   = 2,
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_stall,
    output logic        busy,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hold_q, hold_d;          // response data, already zeroed for stores and misaligned accesses
    logic        err_q, err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem [2**ADDR_BITS];

    logic [ADDR_BITS-1:0] idx_in;
    logic                 misalign;
    logic                 accept;
    logic [31:0]          acc_data;
    logic                 unused_addr_hi;

    // Upper address bits are ignored, so addresses wrap modulo the storage depth.
    assign idx_in         = req_addr[ADDR_BITS+1:2];
    assign misalign       = |req_addr[1:0];
    assign accept         = (state_q == S_IDLE) && req_valid;
    assign acc_data       = (req_write || misalign) ? 32'd0 : mem[idx_in];
    assign unused_addr_hi = ^req_addr[31:ADDR_BITS+2];

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            hold_q      <= 32'd0;
            err_q       <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            err_q       <= err_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage is not cleared by reset. An aligned store commits on its accept edge, so it
    // survives a reset that arrives later in the transaction.
    always_ff @(posedge clk) begin
        if (!rst && accept && req_write && !misalign) begin
            mem[idx_in] <= req_wdata;
        end
    end

    // Next-state logic. The response registers load on the edge that enters RESP,
    // and then hold their values until the next response.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        err_d       = err_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cnt_d  = CNT_INIT;
                    hold_d = acc_data;
                    err_d  = misalign;
                    if (LATENCY == 1) begin
                        // The hold register is bypassed, because RESP follows the accept edge directly.
                        state_d     = S_RESP;
                        rsp_rdata_d = acc_data;
                        rsp_err_d   = misalign;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d     = S_RESP;
                    rsp_rdata_d = hold_q;
                    rsp_err_d   = err_q;
                end
            end
            S_RESP: begin
                // req_valid is still high here for the retiring transaction, so it is not re-accepted.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        busy      = (state_q != S_IDLE);
        mem_stall = ((state_q == S_IDLE) && req_valid) || (state_q == S_WAIT);
        rsp_valid = (state_q == S_RESP);
        rsp_rdata = rsp_rdata_q;
        rsp_err   = rsp_err_q;
    end

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // DUT with LATENCY=2
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        mem_stall, busy, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    // DUT with LATENCY=1
    logic        req_valid1 = 1'b0, req_write1 = 1'b0;
    logic [31:0] req_addr1 = '0, req_wdata1 = '0;
    logic        mem_stall1, busy1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_rdata1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.LATENCY(2), .ADDR_BITS(10)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_stall(mem_stall), .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_memory_responder #(.LATENCY(1), .ADDR_BITS(10)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_write(req_write1), .req_addr(req_addr1), .req_wdata(req_wdata1),
        .mem_stall(mem_stall1), .busy(busy1), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // This task runs one LATENCY=2 transaction, from the request cycle through RESP.
    // If hold=1, req_valid stays high after RESP (back-to-back case), and the idle
    // cycle is then checked by the next call.
    task automatic txn2(input string tag, input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input logic hold);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = addr; req_wdata = wdata;
        #1;
        chk({tag, ".req_stall"}, 32'(mem_stall), 32'd1);
        chk({tag, ".req_busy"},  32'(busy),      32'd0);
        chk({tag, ".req_rv"},    32'(rsp_valid), 32'd0);
        @(negedge clk);                       // WAIT
        req_addr = addr ^ 32'h4;              // changes made while busy must be ignored
        req_wdata = ~wdata;
        #1;
        chk({tag, ".wait_stall"}, 32'(mem_stall), 32'd1);
        chk({tag, ".wait_busy"},  32'(busy),      32'd1);
        chk({tag, ".wait_rv"},    32'(rsp_valid), 32'd0);
        @(negedge clk);                       // RESP
        #1;
        chk({tag, ".resp_rv"},    32'(rsp_valid), 32'd1);
        chk({tag, ".resp_stall"}, 32'(mem_stall), 32'd0);
        chk({tag, ".resp_rdata"}, rsp_rdata,      exp_rd);
        chk({tag, ".resp_err"},   32'(rsp_err),   32'(exp_err));
        if (!hold) begin
            req_valid = 1'b0;
            @(negedge clk);
            #1;
            chk({tag, ".post_rv"},    32'(rsp_valid), 32'd0);
            chk({tag, ".post_busy"},  32'(busy),      32'd0);
            chk({tag, ".post_stall"}, 32'(mem_stall), 32'd0);
            chk({tag, ".post_rdata"}, rsp_rdata,      exp_rd);
        end
    endtask

    // This task runs one LATENCY=1 transaction on the second instance.
    task automatic txn1(input string tag, input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd);
        @(negedge clk);
        req_valid1 = 1'b1; req_write1 = w; req_addr1 = addr; req_wdata1 = wdata;
        #1;
        chk({tag, ".req_stall"}, 32'(mem_stall1), 32'd1);
        chk({tag, ".req_rv"},    32'(rsp_valid1), 32'd0);
        @(negedge clk);                       // RESP directly after the accept edge
        #1;
        chk({tag, ".resp_rv"},    32'(rsp_valid1), 32'd1);
        chk({tag, ".resp_stall"}, 32'(mem_stall1), 32'd0);
        chk({tag, ".resp_rdata"}, rsp_rdata1,      exp_rd);
        req_valid1 = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, ".post_rv"},   32'(rsp_valid1), 32'd0);
        chk({tag, ".post_busy"}, 32'(busy1),      32'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst.rv",    32'(rsp_valid), 32'd0);
        chk("rst.busy",  32'(busy),      32'd0);
        chk("rst.stall", 32'(mem_stall), 32'd0);
        chk("rst.rdata", rsp_rdata,      32'd0);
        chk("rst.err",   32'(rsp_err),   32'd0);
        rst = 1'b0;

        // 1) Store, then 2) load it back
        txn2("st10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        txn2("ld10", 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0);

        // 3) Address wrap: 0x1010 and 0x0010 map to the same word
        txn2("st1010", 1'b1, 32'h1010, 32'h00001234, 32'h0, 1'b0, 1'b0);
        txn2("ldwrap", 1'b0, 32'h0010, 32'h0,        32'h00001234, 1'b0, 1'b0);

        // 4) A misaligned store is flagged and does not write
        txn2("st20",   1'b1, 32'h20, 32'h11112222, 32'h0, 1'b0, 1'b0);
        txn2("stmis",  1'b1, 32'h22, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
        txn2("ld20",   1'b0, 32'h20, 32'h0,        32'h11112222, 1'b0, 1'b0);

        // 5) Back-to-back loads with req_valid held: one idle cycle and no duplicate accept
        txn2("b2b_a",  1'b0, 32'h10, 32'h0, 32'h00001234, 1'b0, 1'b1);
        txn2("b2b_b",  1'b0, 32'h20, 32'h0, 32'h11112222, 1'b0, 1'b0);

        // A misaligned load returns zero data and sets err
        txn2("ldmis",  1'b0, 32'h21, 32'h0, 32'h0, 1'b1, 1'b0);
        txn2("ld20b",  1'b0, 32'h20, 32'h0, 32'h11112222, 1'b0, 1'b0);

        // 6) Reset during WAIT: no response, outputs return to reset values, and the store persists
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
        @(negedge clk);                       // WAIT
        #1;
        chk("rstw.busy_before", 32'(busy), 32'd1);
        rst = 1'b1; req_valid = 1'b0;
        #1;
        chk("rstw.rv",    32'(rsp_valid), 32'd0);
        chk("rstw.busy",  32'(busy),      32'd0);
        chk("rstw.stall", 32'(mem_stall), 32'd0);
        chk("rstw.rdata", rsp_rdata,      32'd0);
        chk("rstw.err",   32'(rsp_err),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rstw.rv_after", 32'(rsp_valid), 32'd0);
        txn2("ld40", 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);

        // LATENCY=1 sweep
        txn1("l1_st",  1'b1, 32'h8,   32'hA5A5A5A5, 32'h0);
        txn1("l1_ld",  1'b0, 32'h8,   32'h0,        32'hA5A5A5A5);
        txn1("l1_st2", 1'b1, 32'h100, 32'h0BADF00D, 32'h0);
        txn1("l1_ld2", 1'b0, 32'h100, 32'h0,        32'h0BADF00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
